soc1_sysid_checker: RTL

Avalon-MM read master that sits on the SoC1 interconnect opposite the system-ID peripheral and confirms the FPGA image at boot. After reset, or on a `start` pulse, it reads the ID word (word address 0) and the timestamp word (word address 1). It compares both against build-time parameters and presents pass/fail flags and the captured values to the status/LED logic and the host CPU.

---
 rtl/soc1_sysid_checker.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/soc1_sysid_checker.sv
// Boot-time system-ID checker: Avalon-MM read master that fetches the ID and timestamp words and compares them.
// Optional per-transaction timeout enabled by defining SOC1_SYSID_CHECK_TIMEOUT_EN.
module soc1_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1730382123,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ID_REQ  = 3'd1;
  localparam logic [2:0] S_ID_WAIT = 3'd2;
  localparam logic [2:0] S_TS_REQ  = 3'd3;
  localparam logic [2:0] S_TS_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("soc1_sysid_checker: TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [2:0]  state_q, state_d;
  logic        auto_q, auto_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;
  logic        clr;
  logic        in_xfer;

`ifdef SOC1_SYSID_CHECK_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             tmo_hit;

  // Compare against cnt+1 so DONE appears exactly TIMEOUT_CYCLES cycles after REQ entry.
  assign tmo_hit = ((CNT_W+1)'(cnt_q) + (CNT_W+1)'(1)) >= (CNT_W+1)'(TIMEOUT_CYCLES);
`endif

  assign in_xfer = (state_q == S_ID_REQ) || (state_q == S_ID_WAIT) ||
                   (state_q == S_TS_REQ) || (state_q == S_TS_WAIT);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    auto_d   = 1'b0;
    id_ok_d  = id_ok_q;
    ts_ok_d  = ts_ok_q;
    id_val_d = id_val_q;
    ts_val_d = ts_val_q;
    clr      = 1'b0;
`ifdef SOC1_SYSID_CHECK_TIMEOUT_EN
    to_d     = to_q;
    cnt_d    = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d = S_ID_REQ;
          clr     = 1'b1;
        end
      end
      S_ID_REQ: begin
        if (!avm_waitrequest) state_d = S_ID_WAIT;
      end
      S_ID_WAIT: begin
        if (avm_readdatavalid) begin
          id_val_d = avm_readdata;
          id_ok_d  = (avm_readdata == EXPECTED_ID);
          state_d  = S_TS_REQ;
        end
      end
      S_TS_REQ: begin
        if (!avm_waitrequest) state_d = S_TS_WAIT;
      end
      S_TS_WAIT: begin
        if (avm_readdatavalid) begin
          ts_val_d = avm_readdata;
          ts_ok_d  = (avm_readdata == EXPECTED_TIMESTAMP);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_ID_REQ;
          clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SOC1_SYSID_CHECK_TIMEOUT_EN
    // A stalled transaction is abandoned; progress on the same cycle wins.
    if (in_xfer && (state_d == state_q) && tmo_hit) begin
      state_d = S_DONE;
      to_d    = 1'b1;
    end
    if ((state_d != state_q) && ((state_d == S_ID_REQ) || (state_d == S_TS_REQ)))
      cnt_d = '0;
    else if (in_xfer)
      cnt_d = CNT_W'(cnt_q + CNT_W'(1));
    if (clr) to_d = 1'b0;
`endif

    if (clr) begin
      id_ok_d  = 1'b0;
      ts_ok_d  = 1'b0;
      id_val_d = '0;
      ts_val_d = '0;
    end

    read_d = (state_d == S_ID_REQ) || (state_d == S_TS_REQ);
    addr_d = (state_d == S_TS_REQ);
    busy_d = (state_d == S_ID_REQ) || (state_d == S_ID_WAIT) ||
             (state_d == S_TS_REQ) || (state_d == S_TS_WAIT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      auto_q   <= AUTO_START;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
    end
  end

`ifdef SOC1_SYSID_CHECK_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule
